morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter: UNIT_CYCLES, default 6_000_000, clock cycles per Morse time unit (60 ms at 100 MHz); legal range is 2 or more.
REQ-002 Port: clk_100Mhz  input  1  system clock; everything is on the rising edge.
REQ-003 Port: reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-004 Port: char_valid  input  1  upstream offers a character.
REQ-005 Port: char_ready  output  1  block can accept a character this cycle.
REQ-006 Port: sym_len  input  3  element count, 0..5; values 6..7 are clamped to 5.
REQ-007 Port: sym_bits  input  5  element pattern, LSB sent first; 1 = dash, 0 = dot.
REQ-008 Port: word_gap  input  1  after the character, emit a word gap instead of a character gap.
REQ-009 Port: key_out  output  1  Morse keying; 1 = tone/LED on.
REQ-010 Port: busy  output  1  high from acceptance until the trailing gap ends.
REQ-011 Port: char_done  output  1  one-cycle pulse on the last cycle of the trailing gap.

Function
REQ-012 Handshake: a transfer occurs when char_valid and char_ready are both 1 in the same cycle; sym_len, sym_bits and word_gap are captured on that edge.
REQ-013 char_ready: 1 only in IDLE and combinational from state; while busy, char_valid is ignored and no input is sampled.
REQ-014 FSM states: IDLE, MARK, SPACE, TRAIL.
- IDLE -> MARK on transfer when sym_len > 0.
- IDLE -> TRAIL on transfer when sym_len == 0.
REQ-015 MARK: key_out = 1 for exactly 1 unit (dot) or 3 units (dash), where 1 unit = UNIT_CYCLES cycles.
- Then -> SPACE if elements remain.
- Else -> TRAIL.
REQ-016 SPACE: key_out = 0 for exactly 1 unit (intra-character gap), then -> MARK on the next element.
REQ-017 TRAIL: key_out = 0 for exactly 3 units (character gap), or 7 units if word_gap was captured; then -> IDLE.
REQ-018 sym_len == 0 is a pure gap: no marks, TRAIL length still follows word_gap.
REQ-019 Latency: key_out rises on the first edge after the transfer edge. The unit timer is restarted on that transfer edge, so every interval is cycle-exact with no residue from earlier timing.
REQ-020 Element selection: the element index runs 0..len-1, and the captured sym_bits is shifted right one bit per element; bits at or above sym_len are ignored.
REQ-021 char_done asserts in the final cycle of TRAIL; char_ready asserts in the next cycle.
- Back-to-back transfers are therefore spaced by exactly the character's total duration plus one IDLE cycle.
REQ-022 busy = (state != IDLE).
REQ-023 Counters: the unit-cycle counter is sized $clog2(UNIT_CYCLES); the unit counter is 3 bits (maximum 7). Neither counter wraps in legal operation.

Reset
REQ-024 While reset = 0, all of the following hold:
- state = IDLE
- key_out = 0, busy = 0, char_done = 0
- char_ready = 1
- counters and captured data cleared
REQ-025 Reset asserted mid-character drops key_out to 0 asynchronously (no completion of the current element) and discards the character. After release, the block accepts a new character in the first cycle.

Structure
REQ-026 Shared package morse_pkg holds:
- the state enum type
- unit constants DOT_UNITS = 1, DASH_UNITS = 3, ELEM_GAP_UNITS = 1, CHAR_GAP_UNITS = 3, WORD_GAP_UNITS = 7
- MAX_ELEMS = 5
REQ-027 One sub-module, morse_unit_timer (parameter UNIT_CYCLES):
- inputs: restart, enable
- output: unit_tick, a one-cycle pulse every UNIT_CYCLES cycles after restart
- the FSM counts unit_tick pulses against the package constants

Verification (UNIT_CYCLES = 4)
REQ-028 'E' (sym_len = 1, sym_bits = 0, word_gap = 0) -> key_out 1 for 4 cycles starting 1 cycle after transfer, then 0 for 12 cycles; char_done on the 16th cycle; char_ready on the 17th.
REQ-029 'A' (sym_len = 2, sym_bits = 5'b00010) -> key_out 1 for 4, 0 for 4, 1 for 12, 0 for 12; busy high for 32 cycles.
REQ-030 Word space (sym_len = 0, word_gap = 1) -> key_out stays 0; busy high for 28 cycles; one char_done pulse.
REQ-031 Backpressure: char_valid held high with changing data throughout 'T' (sym_len = 1, sym_bits = 1) -> only the first character is sent (12 on, 12 off); the next transfer occurs on the first char_ready cycle.
REQ-032 Reset pulse at cycle 6 of a dash -> key_out = 0 in the same cycle; busy = 0, char_ready = 1 after release; a following 'E' times exactly as in REQ-028.
REQ-033 sym_len = 7, sym_bits = 5'b11111 -> exactly 5 dashes are emitted (clamp), each 12 cycles with 4-cycle gaps, then a 12-cycle trailing gap.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse transmitter.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_TRAIL
  } morse_state_e;

  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned ELEM_GAP_UNITS = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 7;
  localparam int unsigned MAX_ELEMS      = 5;

  localparam int unsigned LEN_W   = 3;
  localparam int unsigned BITS_W  = 5;
  localparam int unsigned UNITS_W = 3;

  // Captured character: remaining element count, pending pattern, gap type
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [BITS_W-1:0] bits;
    logic              word_gap;
  } morse_char_t;

  // Length in units of the interval spent in a given state
  function automatic logic [UNITS_W-1:0] interval_units(input morse_state_e st,
                                                        input logic         dash,
                                                        input logic         wgap);
    logic [UNITS_W-1:0] u;
    u = UNITS_W'(1);
    case (st)
      ST_MARK:  u = dash ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
      ST_SPACE: u = UNITS_W'(ELEM_GAP_UNITS);
      ST_TRAIL: u = wgap ? UNITS_W'(WORD_GAP_UNITS) : UNITS_W'(CHAR_GAP_UNITS);
      default:  u = UNITS_W'(1);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_tx_if.sv
// Character handshake between an upstream source (master) and morse_tx (slave).
//   char_valid : source offers a character
//   char_ready : transmitter can accept this cycle
//   sym_len    : element count 0..5 (6..7 clamp to 5)
//   sym_bits   : element pattern, LSB first, 1 = dash
//   word_gap   : follow the character with a word gap
interface morse_tx_if;
  import morse_pkg::*;

  logic              char_valid;
  logic              char_ready;
  logic [LEN_W-1:0]  sym_len;
  logic [BITS_W-1:0] sym_bits;
  logic              word_gap;

  modport master (
    output char_valid, sym_len, sym_bits, word_gap,
    input  char_ready
  );

  modport slave (
    input  char_valid, sym_len, sym_bits, word_gap,
    output char_ready
  );

endinterface

// File: rtl/morse_unit_timer.sv
// Morse unit timebase: one-cycle unit_tick on the last cycle of every
// UNIT_CYCLES-cycle unit, phase-aligned to the most recent restart.
//   clk, rst_n : clock, async active-low reset
//   restart    : zero the phase (the unit starts in the following cycle)
//   enable     : count while high; tick held low otherwise
//   unit_tick  : registered pulse closing each unit
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 6_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic unit_tick
);

  localparam int unsigned CNT_W = $clog2(UNIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered one count early so it lands on the unit's last cycle
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d  = (cnt_q == CNT_W'(UNIT_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(UNIT_CYCLES - 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign unit_tick = tick_q;

endmodule

// File: rtl/morse_tx.sv
// Morse code keyer: accepts one character at a time and keys its dots and
// dashes, intra-character gaps, and a trailing character or word gap.
//   clk_100Mhz : system clock
//   reset      : async active-low reset
//   chr        : character handshake (slave side)
//   key_out    : keying output, 1 = tone on
//   busy       : character in progress
//   char_done  : pulse on the last cycle of the trailing gap
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6_000_000
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  morse_tx_if.slave  chr,
  output logic       key_out,
  output logic       busy,
  output logic       char_done
);

  morse_state_e        state_q, state_d;
  morse_char_t         char_q, char_d;
  logic [UNITS_W-1:0]  units_q, units_d;
  logic                key_q, key_d;

  logic                unit_tick;
  logic                xfer;
  logic                last_unit;
  logic [UNITS_W-1:0]  target;
  logic [LEN_W-1:0]    len_clamped;

  assign xfer        = chr.char_valid && (state_q == ST_IDLE);
  assign len_clamped = (chr.sym_len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : chr.sym_len;
  assign target      = interval_units(state_q, char_q.bits[0], char_q.word_gap);
  assign last_unit   = unit_tick && (units_q == target - UNITS_W'(1));

  // Timer free-runs while busy; restarting it on acceptance removes idle residue
  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk       (clk_100Mhz),
    .rst_n     (reset),
    .restart   (xfer),
    .enable    (state_q != ST_IDLE),
    .unit_tick (unit_tick)
  );

  // Next-state: capture on acceptance, then step through intervals on unit ticks
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    units_d = units_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          char_d.len      = len_clamped;
          char_d.bits     = chr.sym_bits;
          char_d.word_gap = chr.word_gap;
          units_d         = '0;
          state_d         = (len_clamped != '0) ? ST_MARK : ST_TRAIL;
        end
      end
      ST_MARK, ST_SPACE, ST_TRAIL: begin
        if (unit_tick) begin
          if (!last_unit) begin
            units_d = units_q + UNITS_W'(1);
          end else begin
            units_d = '0;
            case (state_q)
              ST_MARK: begin
                // Consume the element just sent; bits[0] is always the current one
                char_d.bits = char_q.bits >> 1;
                char_d.len  = char_q.len - LEN_W'(1);
                state_d     = (char_q.len > LEN_W'(1)) ? ST_SPACE : ST_TRAIL;
              end
              ST_SPACE: state_d = ST_MARK;
              default:  state_d = ST_IDLE;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    key_d = (state_d == ST_MARK);
  end

  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      char_q  <= '0;
      units_q <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      units_q <= units_d;
      key_q   <= key_d;
    end
  end

  assign key_out        = key_q;
  assign busy           = (state_q != ST_IDLE);
  assign chr.char_ready = (state_q == ST_IDLE);
  // Decoded from registered state/timer so it marks the gap's final cycle exactly
  assign char_done      = (state_q == ST_TRAIL) && last_unit;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES = 4.
module tb_morse_tx;
  import morse_pkg::*;

  localparam int unsigned UNIT = 4;

  logic clk_100Mhz;
  logic reset;
  logic key_out;
  logic busy;
  logic char_done;

  morse_tx_if chr_if ();

  morse_tx #(
    .UNIT_CYCLES (UNIT)
  ) dut (
    .clk_100Mhz (clk_100Mhz),
    .reset      (reset),
    .chr        (chr_if),
    .key_out    (key_out),
    .busy       (busy),
    .char_done  (char_done)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  int n_checks;
  int n_fail;

  // Observations from the most recent capture
  int runs[$];
  int exp_q[$];
  int first_lvl;
  int busy_cycles;
  int done_cnt;
  int done_pos;
  int ended;
  int ready_at_end;
  int ready_while_busy;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer a character and complete the transfer edge; returns #1 after that edge
  task automatic send(input logic [2:0] len, input logic [4:0] bits, input logic wg,
                      input bit keep_valid);
    int waited;
    chr_if.sym_len    = len;
    chr_if.sym_bits   = bits;
    chr_if.word_gap   = wg;
    chr_if.char_valid = 1'b1;
    waited = 0;
    @(negedge clk_100Mhz);
    while (!chr_if.char_ready && waited < 200) begin
      @(negedge clk_100Mhz);
      waited++;
    end
    check("send_ready_wait", int'(chr_if.char_ready), 1);
    @(posedge clk_100Mhz);
    #1;
    if (!keep_valid) chr_if.char_valid = 1'b0;
  endtask

  // Sample each cycle after the transfer edge until busy falls
  task automatic capture(input bit wiggle);
    int cur;
    int len;
    cur = -1; len = 0;
    runs.delete();
    first_lvl = -1; busy_cycles = 0; done_cnt = 0; done_pos = 0;
    ended = 0; ready_at_end = 0; ready_while_busy = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk_100Mhz);
      if (!busy) begin
        ended = 1;
        ready_at_end = int'(chr_if.char_ready);
        break;
      end
      busy_cycles++;
      if (chr_if.char_ready) ready_while_busy++;
      if (char_done) begin
        done_cnt++;
        done_pos = c;
      end
      if (int'(key_out) == cur) begin
        len++;
      end else begin
        if (cur >= 0) runs.push_back(len);
        else first_lvl = int'(key_out);
        cur = int'(key_out);
        len = 1;
      end
      if (wiggle) begin
        chr_if.sym_len  = 3'($urandom);
        chr_if.sym_bits = 5'($urandom);
        chr_if.word_gap = 1'($urandom);
      end
    end
    if (len > 0) runs.push_back(len);
  endtask

  // Compare the capture against exp_q and the expected busy length
  task automatic verify(input string name, input int exp_first, input int exp_busy);
    int n;
    check({name, ".ended"}, ended, 1);
    check({name, ".first_level"}, first_lvl, exp_first);
    check({name, ".busy_cycles"}, busy_cycles, exp_busy);
    check({name, ".run_count"}, runs.size(), exp_q.size());
    n = (runs.size() < exp_q.size()) ? runs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.run%0d", name, i), runs[i], exp_q[i]);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".done_cycle"}, done_pos, exp_busy);
    check({name, ".ready_after"}, ready_at_end, 1);
    check({name, ".ready_while_busy"}, ready_while_busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chr_if.char_valid = 1'b0;
    chr_if.sym_len    = '0;
    chr_if.sym_bits   = '0;
    chr_if.word_gap   = 1'b0;
    reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_100Mhz);
    check("rst.key_out", int'(key_out), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.char_done", int'(char_done), 0);
    check("rst.char_ready", int'(chr_if.char_ready), 1);
    reset = 1'b1;
    @(negedge clk_100Mhz);

    // 'E': one dot then character gap
    send(3'd1, 5'b00000, 1'b0, 1'b0);
    capture(1'b0);
    exp_q = '{4, 12};
    verify("E", 1, 16);

    // 'A': dot, gap, dash, character gap
    send(3'd2, 5'b00010, 1'b0, 1'b0);
    capture(1'b0);
    exp_q = '{4, 4, 12, 12};
    verify("A", 1, 32);

    // Word space: no marks, seven-unit gap
    send(3'd0, 5'b10101, 1'b1, 1'b0);
    capture(1'b0);
    exp_q = '{28};
    verify("WS", 0, 28);

    // Bits above sym_len ignored: 'N' = dash, dot with junk in upper bits
    send(3'd2, 5'b11101, 1'b1, 1'b0);
    capture(1'b0);
    exp_q = '{12, 4, 4, 28};
    verify("N_wg", 1, 48);

    // Backpressure: 'T' with valid held and data changing while busy
    send(3'd1, 5'b00001, 1'b0, 1'b1);
    capture(1'b1);
    exp_q = '{12, 12};
    verify("T_bp", 1, 24);
    // Still in the first ready cycle: next transfer takes this edge
    chr_if.sym_len  = 3'd1;
    chr_if.sym_bits = 5'b00000;
    chr_if.word_gap = 1'b0;
    @(posedge clk_100Mhz);
    #1;
    chr_if.char_valid = 1'b0;
    capture(1'b0);
    exp_q = '{4, 12};
    verify("E_after_bp", 1, 16);

    // Reset in cycle 6 of a dash
    send(3'd1, 5'b00001, 1'b0, 1'b0);
    repeat (5) @(negedge clk_100Mhz);
    @(posedge clk_100Mhz);
    #1;
    check("rst_mid.key_before", int'(key_out), 1);
    reset = 1'b0;
    #1;
    check("rst_mid.key_async", int'(key_out), 0);
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.ready", int'(chr_if.char_ready), 1);
    @(negedge clk_100Mhz);
    reset = 1'b1;
    @(negedge clk_100Mhz);
    check("rst_rel.busy", int'(busy), 0);
    check("rst_rel.ready", int'(chr_if.char_ready), 1);
    check("rst_rel.key", int'(key_out), 0);
    send(3'd1, 5'b00000, 1'b0, 1'b0);
    capture(1'b0);
    exp_q = '{4, 12};
    verify("E_after_rst", 1, 16);

    // Clamp: sym_len 7 gives exactly five dashes
    send(3'd7, 5'b11111, 1'b0, 1'b0);
    capture(1'b0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(12);
      exp_q.push_back(4);
    end
    exp_q.push_back(12);
    exp_q.push_back(12);
    verify("clamp7", 1, 88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
